// File: rtl/bit_word_packer_if.sv
// Busy/vld channels of the bit-to-word packer: a 1-bit input stream and a word-wide output stream.
interface bit_word_packer_if #(
   parameter int unsigned DATA_W = 16
) ();
   localparam int unsigned NbitsW = $clog2(DATA_W + 1);

   logic              din_vld;
   logic              din_data;
   logic              din_last;
   logic              din_busy;
   logic              dout_busy;
   logic              dout_vld;
   logic [DATA_W-1:0] dout_data;
   logic              dout_last;
   logic [NbitsW-1:0] dout_nbits;

   modport master (
      output din_vld, din_data, din_last, dout_busy,
      input  din_busy, dout_vld, dout_data, dout_last, dout_nbits
   );

   modport slave (
      input  din_vld, din_data, din_last, dout_busy,
      output din_busy, dout_vld, dout_data, dout_last, dout_nbits
   );
endinterface

// File: rtl/bit_word_packer.sv
// Packs a serial bit stream into DATA_W-bit words (MSB- or LSB-first) with early packet close
// and zero padding, buffering finished words in an OUT_DEPTH-entry circular queue.
module bit_word_packer #(
   parameter int unsigned DATA_W    = 16,
   parameter bit          MSB_FIRST = 1'b1,
   parameter int unsigned OUT_DEPTH = 2
) (
   input logic              clk,
   input logic              rst,
   bit_word_packer_if.slave bus
);
   localparam int unsigned CntW = $clog2(DATA_W);
   localparam int unsigned NbW  = $clog2(DATA_W + 1);
   localparam int unsigned PtrW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int unsigned OccW = $clog2(OUT_DEPTH + 1);

   logic [DATA_W-1:0] sr_q, sr_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [OccW-1:0]   occ_q, occ_d;

   logic [DATA_W-1:0] mem_data_q  [OUT_DEPTH];
   logic [DATA_W-1:0] mem_data_d  [OUT_DEPTH];
   logic              mem_last_q  [OUT_DEPTH];
   logic              mem_last_d  [OUT_DEPTH];
   logic [NbW-1:0]    mem_nbits_q [OUT_DEPTH];
   logic [NbW-1:0]    mem_nbits_d [OUT_DEPTH];

   logic              full;
   logic              empty;
   logic              din_busy;
   logic              in_xfer;
   logic              out_xfer;
   logic              word_done;
   logic [CntW-1:0]   bit_pos;
   logic [DATA_W-1:0] word;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(OUT_DEPTH - 1)) ? '0 : p + PtrW'(1);
   endfunction

   // Handshake flags depend only on registered occupancy, never on dout_busy.
   assign full     = (occ_q == OccW'(OUT_DEPTH));
   assign empty    = (occ_q == '0);
   assign din_busy = rst | full;
   assign in_xfer  = bus.din_vld & ~din_busy;
   assign out_xfer = ~empty & ~bus.dout_busy;
   assign word_done = in_xfer & (bus.din_last | (cnt_q == CntW'(DATA_W - 1)));

   always_comb begin
      bit_pos = MSB_FIRST ? (CntW'(DATA_W - 1) - cnt_q) : cnt_q;
      word    = sr_q;
      word[bit_pos] = bus.din_data;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      if (in_xfer) begin
         if (word_done) begin
            sr_d  = '0;
            cnt_d = '0;
         end else begin
            sr_d  = word;
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_comb begin
      mem_data_d  = mem_data_q;
      mem_last_d  = mem_last_q;
      mem_nbits_d = mem_nbits_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      occ_d       = occ_q;
      if (word_done) begin
         mem_data_d[wr_ptr_q]  = word;
         mem_last_d[wr_ptr_q]  = bus.din_last;
         mem_nbits_d[wr_ptr_q] = NbW'(cnt_q) + NbW'(1);
         wr_ptr_d              = ptr_inc(wr_ptr_q);
      end
      if (out_xfer) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (word_done && !out_xfer) begin
         occ_d = occ_q + OccW'(1);
      end else if (!word_done && out_xfer) begin
         occ_d = occ_q - OccW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q     <= '0;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         sr_q     <= sr_d;
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Storage needs no reset: outputs are masked to zero while the queue is empty.
   always_ff @(posedge clk) begin
      mem_data_q  <= mem_data_d;
      mem_last_q  <= mem_last_d;
      mem_nbits_q <= mem_nbits_d;
   end

   assign bus.din_busy   = din_busy;
   assign bus.dout_vld   = ~empty;
   assign bus.dout_data  = empty ? '0 : mem_data_q[rd_ptr_q];
   assign bus.dout_last  = empty ? 1'b0 : mem_last_q[rd_ptr_q];
   assign bus.dout_nbits = empty ? '0 : mem_nbits_q[rd_ptr_q];

`ifndef SYNTHESIS
   a_occ_bound : assert property (@(posedge clk) disable iff (rst)
      occ_q <= OccW'(OUT_DEPTH));
   a_out_stable : assert property (@(posedge clk) disable iff (rst)
      (bus.dout_vld && bus.dout_busy) |=>
         (bus.dout_vld && $stable(bus.dout_data) && $stable(bus.dout_last)
          && $stable(bus.dout_nbits)));
`endif
endmodule

// File: tb/tb_bit_word_packer.sv
// Randomised and directed bench for bit_word_packer: MSB-first and LSB-first instances share
// stimulus and are compared every cycle against a queue-based model.
module tb_bit_word_packer;
   localparam int unsigned W     = 16;
   localparam int unsigned DEPTH = 2;

   typedef struct {
      logic [W-1:0] wm;
      logic [W-1:0] wl;
      logic         last;
      int           nbits;
   } entry_t;

   logic clk       = 1'b0;
   logic rst       = 1'b1;
   logic din_vld   = 1'b0;
   logic din_data  = 1'b0;
   logic din_last  = 1'b0;
   logic dout_busy = 1'b0;

   entry_t exp_q[$];
   bit     cur_bits[$];
   int     n_checks = 0;
   int     n_pass   = 0;
   int     acc_cnt  = 0;
   int     busy_seen;
   logic [15:0] pat;

   always #5 clk = ~clk;

   bit_word_packer_if #(.DATA_W(W)) bus_m ();
   bit_word_packer_if #(.DATA_W(W)) bus_l ();

   assign bus_m.din_vld   = din_vld;
   assign bus_m.din_data  = din_data;
   assign bus_m.din_last  = din_last;
   assign bus_m.dout_busy = dout_busy;
   assign bus_l.din_vld   = din_vld;
   assign bus_l.din_data  = din_data;
   assign bus_l.din_last  = din_last;
   assign bus_l.dout_busy = dout_busy;

   bit_word_packer #(.DATA_W(W), .MSB_FIRST(1'b1), .OUT_DEPTH(DEPTH)) dut_m (
      .clk (clk),
      .rst (rst),
      .bus (bus_m)
   );

   bit_word_packer #(.DATA_W(W), .MSB_FIRST(1'b0), .OUT_DEPTH(DEPTH)) dut_l (
      .clk (clk),
      .rst (rst),
      .bus (bus_l)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Model of one rising edge, using the inputs as they stand at that edge.
   function automatic void model_edge();
      entry_t e;
      bit     in_x;
      bit     out_x;
      if (rst) begin
         exp_q.delete();
         cur_bits.delete();
      end else begin
         in_x  = din_vld && (exp_q.size() != DEPTH);
         out_x = (exp_q.size() != 0) && !dout_busy;
         if (out_x) void'(exp_q.pop_front());
         if (in_x) begin
            acc_cnt++;
            cur_bits.push_back(din_data);
            if (cur_bits.size() == W || din_last) begin
               e.wm = '0;
               e.wl = '0;
               for (int i = 0; i < cur_bits.size(); i++) begin
                  e.wm[W-1-i] = cur_bits[i];
                  e.wl[i]     = cur_bits[i];
               end
               e.last  = din_last;
               e.nbits = cur_bits.size();
               exp_q.push_back(e);
               cur_bits.delete();
            end
         end
      end
   endfunction

   task automatic step(input logic v, input logic d, input logic l, input logic b,
                       input logic r);
      din_vld   = v;
      din_data  = d;
      din_last  = l;
      dout_busy = b;
      rst       = r;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   always @(negedge clk) begin
      chk("din_busy_m", bus_m.din_busy, (rst || exp_q.size() == DEPTH));
      chk("din_busy_l", bus_l.din_busy, (rst || exp_q.size() == DEPTH));
      if (!rst) begin
         chk("dout_vld_m", bus_m.dout_vld, (exp_q.size() != 0));
         chk("dout_vld_l", bus_l.dout_vld, (exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            chk("data_m",  bus_m.dout_data,  exp_q[0].wm);
            chk("data_l",  bus_l.dout_data,  exp_q[0].wl);
            chk("last_m",  bus_m.dout_last,  exp_q[0].last);
            chk("last_l",  bus_l.dout_last,  exp_q[0].last);
            chk("nbits_m", bus_m.dout_nbits, exp_q[0].nbits);
            chk("nbits_l", bus_l.dout_nbits, exp_q[0].nbits);
         end
      end
   end

   initial begin
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("rst_vld",   bus_m.dout_vld,   0);
      chk("rst_data",  bus_m.dout_data,  0);
      chk("rst_last",  bus_l.dout_last,  0);
      chk("rst_nbits", bus_l.dout_nbits, 0);
      chk("rst_busy",  bus_m.din_busy,   1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("busy_after_rst", bus_m.din_busy, 0);

      // Alternating 16-bit packet.
      for (int i = 0; i < 16; i++) begin
         step(1'b1, (i % 2) == 0, i == 15, 1'b0, 1'b0);
         if (i == 14) chk("vld_before_16", bus_m.dout_vld, 0);
      end
      chk("aaaa_model", exp_q[0].wm,      16'hAAAA);
      chk("aaaa_m",     bus_m.dout_data,  16'hAAAA);
      chk("5555_l",     bus_l.dout_data,  16'h5555);
      chk("aaaa_last",  bus_m.dout_last,  1);
      chk("aaaa_nbits", bus_m.dout_nbits, 16);

      // Short 3-bit packet, then a 2-bit packet starting fresh.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, i == 2, 1'b0, 1'b0);
      chk("e000_m",    bus_m.dout_data,  16'hE000);
      chk("0007_l",    bus_l.dout_data,  16'h0007);
      chk("e000_nb",   bus_m.dout_nbits, 3);
      chk("e000_last", bus_l.dout_last,  1);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("8000_m",  bus_m.dout_data,  16'h8000);
      chk("0001_l",  bus_l.dout_data,  16'h0001);
      chk("8000_nb", bus_m.dout_nbits, 2);
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Backpressure: 48 bits offered with the consumer stalled.
      acc_cnt = 0;
      for (int i = 0; i < 48; i++) step(1'b1, 1'($urandom % 2), 1'b0, 1'b1, 1'b0);
      chk("stall_acc",  acc_cnt, 32);
      chk("stall_busy", bus_m.din_busy, 1);
      step(1'b1, 1'($urandom % 2), 1'b0, 1'b0, 1'b0);
      chk("unstall_busy", bus_m.din_busy, 0);
      for (int k = 0; k < 100 && acc_cnt < 48; k++)
         step(1'b1, 1'($urandom % 2), 1'b0, 1'b0, 1'b0);
      chk("stall_acc_all", acc_cnt, 48);
      repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Streaming with an always-ready consumer: input must never stall.
      busy_seen = 0;
      for (int i = 0; i < 200; i++) begin
         step(1'b1, 1'($urandom % 2), ($urandom % 40) == 0, 1'b0, 1'b0);
         if (bus_m.din_busy) busy_seen++;
      end
      chk("overlap_busy", busy_seen, 0);

      // Reset with one word queued and 7 bits in flight.
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 23; i++) step(1'b1, 1'($urandom % 2), 1'b0, 1'b1, 1'b0);
      chk("pre_rst_vld", bus_m.dout_vld, 1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("mid_rst_vld",  bus_m.dout_vld,  0);
      chk("mid_rst_data", bus_l.dout_data, 0);
      chk("mid_rst_busy", bus_m.din_busy,  1);
      pat = 16'hC3A5;
      for (int i = 0; i < 16; i++) step(1'b1, pat[15-i], 1'b0, 1'b0, 1'b0);
      chk("c3a5_m",    bus_m.dout_data,  16'hC3A5);
      chk("a5c3_l",    bus_l.dout_data,  16'hA5C3);
      chk("c3a5_nb",   bus_m.dout_nbits, 16);
      chk("c3a5_last", bus_m.dout_last,  0);

      // Random traffic.
      for (int i = 0; i < 4000; i++)
         step(($urandom % 4) != 0, 1'($urandom % 2), ($urandom % 12) == 0,
              ($urandom % 3) == 0, ($urandom % 300) == 0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
